// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// The CHECK state only exists when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;
`endif

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  localparam int unsigned INST_WORD_BYTES = 4;

endpackage

// File: rtl/prog_loader_ctrl_wdt.sv
// loader_wdt: counts consecutive idle transfer cycles and flags the cycle on
// which the count would reach TIMEOUT_CYC. clr has priority over en.
module loader_wdt #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  // Idle-cycle counter, cleared on any handshake or outside the transfer states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = en && !clr && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/prog_loader_ctrl.sv
// prog_loader_ctrl: boot sequencer that streams host words into instruction
// memory while holding the core in reset, then releases the core.
// Optional checksum word after the program: PROG_LOADER_CHECKSUM_EN.
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | after reset, core held in reset, waiting for start
// LOAD       | accepting words, one instruction-memory write per word
// CHECK      | waiting for the checksum word (checksum build only)
// RELEASE    | flush delay, core still in reset
// RUN        | core running until the next start
// ERROR      | aborted load, core held in reset, err_code holds cause
module prog_loader_ctrl
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MAX_WORDS   = 1024,
  parameter int unsigned LEN_W       = 11,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned RELEASE_DLY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic [31:0]      inst_addr_o,
  output logic [31:0]      inst_data_o,
  output logic             load_en_o,
  output logic             core_rst_n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [LEN_W-1:0] words_loaded
);

  localparam int unsigned RW = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;

  state_t           state, state_d;
  logic [LEN_W-1:0] len_q;
  logic [RW-1:0]    rel_cnt;
  logic [1:0]       err_code_d;
  logic             hs, in_xfer, start_ok, len_bad, last_word;
  logic             wdt_clr, wdt_en, wdt_expire;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0]      csum;
`endif

  assign hs = s_valid & s_ready;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign in_xfer = (state == ST_LOAD) || (state == ST_CHECK);
`else
  assign in_xfer = (state == ST_LOAD);
`endif
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_ERROR));
  assign len_bad   = (len == '0) || (len > LEN_W'(MAX_WORDS));
  assign last_word = ((words_loaded + LEN_W'(1)) == len_q);
  assign wdt_en    = in_xfer && !hs;
  assign wdt_clr   = !in_xfer || hs;
  assign busy      = in_xfer || (state == ST_RELEASE);
  assign err       = (state == ST_ERROR);

  loader_wdt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdt (
    .clk   (clk),
    .rst   (rst),
    .clr   (wdt_clr),
    .en    (wdt_en),
    .expire(wdt_expire)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state and error-cause selection; a handshake always beats the timeout.
  always_comb begin
    state_d    = state;
    err_code_d = err_code;
    case (state)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start) begin
          if (len_bad) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_LEN;
          end else begin
            state_d    = ST_LOAD;
            err_code_d = ERR_NONE;
          end
        end
      end
      ST_LOAD: begin
        if (hs) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (last_word) state_d = ST_CHECK;
`else
          if (last_word) state_d = ST_RELEASE;
`endif
        end else if (wdt_expire) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (hs) begin
          if (s_data == csum) begin
            state_d = ST_RELEASE;
          end else begin
            state_d    = ST_ERROR;
            err_code_d = ERR_CSUM;
          end
        end else if (wdt_expire) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
`endif
      ST_RELEASE: begin
        if (rel_cnt == '0) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs, write path, word counter and release down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready      <= 1'b0;
      load_en_o    <= 1'b0;
      inst_addr_o  <= BASE_ADDR;
      inst_data_o  <= '0;
      core_rst_n   <= 1'b0;
      done         <= 1'b0;
      err_code     <= ERR_NONE;
      words_loaded <= '0;
      len_q        <= '0;
      rel_cnt      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
      s_ready <= (state_d == ST_LOAD) || (state_d == ST_CHECK);
`else
      s_ready <= (state_d == ST_LOAD);
`endif
      load_en_o  <= hs && (state == ST_LOAD);
      core_rst_n <= (state_d == ST_RUN);
      done       <= (state == ST_RELEASE) && (state_d == ST_RUN);
      err_code   <= err_code_d;

      if (hs && (state == ST_LOAD)) begin
        inst_data_o  <= s_data;
        inst_addr_o  <= BASE_ADDR + (32'(words_loaded) * INST_WORD_BYTES);
        words_loaded <= words_loaded + LEN_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
        csum         <= csum + s_data;
`endif
      end

      if (start_ok && !len_bad) begin
        words_loaded <= '0;
        len_q        <= len;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum         <= '0;
`endif
      end

      if ((state_d == ST_RELEASE) && (state != ST_RELEASE)) begin
        rel_cnt <= RW'(RELEASE_DLY - 1);
      end else if ((state == ST_RELEASE) && (rel_cnt != '0)) begin
        rel_cnt <= rel_cnt - RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Self-checking bench for prog_loader_ctrl (small timeout for fast runs).
module tb_prog_loader_ctrl;

  localparam int LW = 11;
  localparam int TO = 16;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          s_valid = 1'b0;
  logic [31:0]   s_data = '0;
  logic          s_ready, load_en_o, core_rst_n, busy, done, err;
  logic [31:0]   inst_addr_o, inst_data_o;
  logic [1:0]    err_code;
  logic [LW-1:0] words_loaded;

  always #5 clk = ~clk;

  prog_loader_ctrl #(
    .BASE_ADDR  (32'h0000_0000),
    .MAX_WORDS  (1024),
    .LEN_W      (LW),
    .TIMEOUT_CYC(TO),
    .RELEASE_DLY(RD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .inst_addr_o (inst_addr_o),
    .inst_data_o (inst_data_o),
    .load_en_o   (load_en_o),
    .core_rst_n  (core_rst_n),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .words_loaded(words_loaded)
  );

  int vectors = 0;
  int errors  = 0;

  // Write monitor: instruction-memory writes and done pulses, sampled mid-cycle.
  logic [31:0] mon_addr[$];
  logic [31:0] mon_data[$];
  int          mon_cyc[$];
  int          done_cnt = 0;
  int          ncyc = 0;
  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      if (load_en_o) begin
        mon_addr.push_back(inst_addr_o);
        mon_data.push_back(inst_data_o);
        mon_cyc.push_back(ncyc);
      end
      if (done) done_cnt++;
    end
  end

  // Expected program image for the load under test.
  logic [31:0] prog[$];

  task automatic clear_mon();
    mon_addr.delete();
    mon_data.delete();
    mon_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [LW-1:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int budget;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_data  = w;
    budget  = 40;
    while (!s_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!s_ready) begin
      vectors++; errors++;
      $display("FAIL handshake_wait: s_ready=%0b after 40 cycles, required 1", s_ready);
    end else begin
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_run(output int low, output bit seen);
    low  = 0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!core_rst_n) low++;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] sum_of_prog();
    logic [31:0] s = '0;
    foreach (prog[i]) s += prog[i];
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    vectors++;
    if ({s_ready, load_en_o, core_rst_n, busy, done, err, err_code, words_loaded, inst_addr_o, inst_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b en=%b crn=%b busy=%b done=%b err=%b code=%0d wl=%0d addr=%h data=%h, required all 0",
               s_ready, load_en_o, core_rst_n, busy, done, err, err_code, words_loaded, inst_addr_o, inst_data_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Writes recorded by the monitor must equal prog[] at BASE + 4*i.
  task automatic check_image(input string name);
    vectors++;
    if (mon_addr.size() != prog.size()) begin
      errors++;
      $display("FAIL %s_count: %0d writes, required %0d", name, mon_addr.size(), prog.size());
    end else begin
      foreach (prog[i]) begin
        vectors++;
        if (mon_addr[i] !== 32'(4 * i) || mon_data[i] !== prog[i]) begin
          errors++;
          $display("FAIL %s_word%0d: addr=%h data=%h, required addr=%h data=%h",
                   name, i, mon_addr[i], mon_data[i], 32'(4 * i), prog[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int  low;
    bit  seen;
    clear_mon();
    prog = '{32'h0050_0093, 32'h0010_8113, 32'h0020_81B3};
    do_start(3);
    foreach (prog[i]) send_word(prog[i], 0);
    vectors++;
    if (load_en_o !== 1'b1 || inst_addr_o !== 32'h8 || inst_data_o !== 32'h0020_81B3) begin
      errors++;
      $display("FAIL b2b_last_write: en=%b addr=%h data=%h, required en=1 addr=00000008 data=002081b3",
               load_en_o, inst_addr_o, inst_data_o);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(sum_of_prog(), 0);
`else
    vectors++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_drop: s_ready=%b, required 0", s_ready);
    end
`endif
    wait_run(low, seen);
    vectors++;
    if (!seen || low != RD) begin
      errors++;
      $display("FAIL b2b_release: done_seen=%0b low_cycles=%0d, required 1 and %0d", seen, low, RD);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (done_cnt != 1 || core_rst_n !== 1'b1 || words_loaded !== LW'(3)) begin
      errors++;
      $display("FAIL b2b_run: done_pulses=%0d crn=%b wl=%0d, required 1, 1, 3", done_cnt, core_rst_n, words_loaded);
    end
    check_image("b2b");
    if (mon_cyc.size() == 3) begin
      vectors++;
      if (mon_cyc[1] - mon_cyc[0] != 1 || mon_cyc[2] - mon_cyc[1] != 1) begin
        errors++;
        $display("FAIL b2b_spacing: write cycles %0d %0d %0d, required consecutive", mon_cyc[0], mon_cyc[1], mon_cyc[2]);
      end
    end
  endtask

  task automatic test_gapped();
    int low;
    bit seen;
    clear_mon();
    prog = '{$urandom(), $urandom()};
    do_start(2);
    foreach (prog[i]) send_word(prog[i], 5);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(sum_of_prog(), 0);
`endif
    wait_run(low, seen);
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL gapped_done: done_seen=%0b, required 1", seen);
    end
    check_image("gapped");
  endtask

  task automatic test_bad_len();
    logic [LW-1:0] bad[2];
    bad[0] = LW'(0);
    bad[1] = LW'(1025);
    foreach (bad[k]) begin
      clear_mon();
      do_start(bad[k]);
      @(negedge clk);
      vectors++;
      if (err !== 1'b1 || err_code !== 2'd1 || core_rst_n !== 1'b0 || s_ready !== 1'b0 || mon_addr.size() != 0) begin
        errors++;
        $display("FAIL bad_len_%0d: err=%b code=%0d crn=%b rdy=%b writes=%0d, required 1, 1, 0, 0, 0",
                 bad[k], err, err_code, core_rst_n, s_ready, mon_addr.size());
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    int low;
    bit seen;
    bit any_en;
    clear_mon();
    prog = '{$urandom(), $urandom()};
    do_start(4);
    foreach (prog[i]) send_word(prog[i], 0);
    n = 0;
    while (!err && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n != TO || err_code !== 2'd2) begin
      errors++;
      $display("FAIL timeout_abort: idle_cycles=%0d code=%0d, required %0d and 2", n, err_code, TO);
    end
    any_en  = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    repeat (10) begin
      @(negedge clk);
      if (load_en_o || s_ready) any_en = 1'b1;
    end
    s_valid = 1'b0;
    vectors++;
    if (any_en || err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_quiet: en_or_ready_seen=%0b err=%b, required 0 and 1", any_en, err);
    end
    check_image("timeout");

    // A word arriving on the terminal-count cycle still wins.
    clear_mon();
    prog = '{$urandom()};
    do_start(1);
    send_word(prog[0], TO - 1);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(sum_of_prog(), 0);
`endif
    wait_run(low, seen);
    vectors++;
    if (!seen || err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_edge: done_seen=%0b err=%b, required 1 and 0", seen, err);
    end
    check_image("timeout_edge");
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int low;
    int n;
    bit seen;
    logic [31:0] chk[2];
    chk[0] = 32'd6;
    chk[1] = 32'd7;
    foreach (chk[k]) begin
      clear_mon();
      prog = '{32'd1, 32'd2, 32'd3};
      do_start(3);
      foreach (prog[i]) send_word(prog[i], 0);
      send_word(chk[k], 0);
      wait_run(low, seen);
      vectors++;
      if (k == 0 && (!seen || err !== 1'b0)) begin
        errors++;
        $display("FAIL csum_good: done_seen=%0b err=%b, required 1 and 0", seen, err);
      end else if (k == 1 && (seen || err !== 1'b1 || err_code !== 2'd3)) begin
        errors++;
        $display("FAIL csum_bad: done_seen=%0b err=%b code=%0d, required 0, 1, 3", seen, err, err_code);
      end
      check_image("csum");
    end
    clear_mon();
    prog = '{$urandom()};
    do_start(1);
    send_word(prog[0], 0);
    n = 0;
    while (!err && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n != TO || err_code !== 2'd2) begin
      errors++;
      $display("FAIL csum_timeout: idle_cycles=%0d code=%0d, required %0d and 2", n, err_code, TO);
    end
  endtask
`endif

  task automatic test_rst_mid();
    int low;
    bit seen;
    clear_mon();
    do_start(4);
    send_word($urandom(), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({s_ready, load_en_o, core_rst_n, busy, done, err, err_code, words_loaded, inst_addr_o, inst_data_o} !== '0) begin
      errors++;
      $display("FAIL rst_mid_values: rdy=%b en=%b crn=%b busy=%b done=%b err=%b code=%0d wl=%0d addr=%h data=%h, required all 0",
               s_ready, load_en_o, core_rst_n, busy, done, err, err_code, words_loaded, inst_addr_o, inst_data_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_mon();
    prog = '{$urandom()};
    do_start(1);
    send_word(prog[0], 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(sum_of_prog(), 0);
`endif
    wait_run(low, seen);
    vectors++;
    if (!seen || words_loaded !== LW'(1)) begin
      errors++;
      $display("FAIL rst_mid_reload: done_seen=%0b wl=%0d, required 1 and 1", seen, words_loaded);
    end
    check_image("rst_mid");
  endtask

  // Random programs with random gaps and ignored start pulses during LOAD.
  task automatic test_random();
    int l, gap, low;
    bit seen, bad;
    for (int it = 0; it < 20; it++) begin
      clear_mon();
      l = $urandom_range(1, 8);
      prog.delete();
      for (int i = 0; i < l; i++) prog.push_back($urandom());
      do_start(LW'(l));
      foreach (prog[i]) begin
        gap = $urandom_range(0, 6);
        for (int g = 0; g < gap; g++) begin
          if (g == 0 && ($urandom() % 3 == 0)) begin
            start = 1'b1;
            len   = '0;
          end
          @(negedge clk);
          start = 1'b0;
        end
        send_word(prog[i], 0);
      end
      bad = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      bad = ($urandom() % 3 == 0);
      send_word(sum_of_prog() + (bad ? 32'd1 : 32'd0), $urandom_range(0, 3));
`endif
      if (bad) begin
        repeat (2) @(negedge clk);
        vectors++;
        if (err !== 1'b1 || err_code !== 2'd3 || done_cnt != 0) begin
          errors++;
          $display("FAIL rand%0d_csum: err=%b code=%0d done=%0d, required 1, 3, 0", it, err, err_code, done_cnt);
        end
      end else begin
        wait_run(low, seen);
        vectors++;
        if (!seen || low != RD || words_loaded !== LW'(l)) begin
          errors++;
          $display("FAIL rand%0d_run: done_seen=%0b low=%0d wl=%0d, required 1, %0d, %0d", it, seen, low, words_loaded, RD, l);
        end
      end
      check_image($sformatf("rand%0d", it));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_bad_len();
    test_timeout();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
